fire_zone_ctrl: RTL and testbench

//   Multi-zone successor to the single-zone fire controller for the home-automation system.

---
 rtl/fire_zone_ctrl.sv | 157 +++++++++++++++
 tb/tb_fire_zone_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fire_zone_ctrl.sv
// Multi-zone fire controller: per-zone sensor debounce plus an
// IDLE/ALARM/EXTINGUISH/COOLDOWN sequencer, with alarm silencing and aggregate status.
//
//   state      | meaning
//   IDLE       | no filtered sensor activity, outputs quiet
//   ALARM      | smoke only, audible alarm unless muted
//   EXTINGUISH | extinguisher driven for at least EXT_MIN cycles
//   COOLDOWN   | sensors clear, waiting CLEAR_HOLD clear cycles before IDLE
module fire_zone_ctrl #(
  parameter int ZONES      = 4,
  parameter int DEBOUNCE   = 3,
  parameter int EXT_MIN    = 8,
  parameter int CLEAR_HOLD = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ZONES-1:0]               heat_signal,
  input  logic [ZONES-1:0]               smoke_signal,
  input  logic                           silence,
  output logic [ZONES-1:0]               alarm,
  output logic [ZONES-1:0]               extinguish,
  output logic                           any_alarm,
  output logic [$clog2(ZONES+1)-1:0]     ext_count
);

  localparam int CW     = $clog2(ZONES+1);
  localparam int DBW    = $clog2(DEBOUNCE+1);
  localparam int TMAX   = (EXT_MIN > CLEAR_HOLD) ? EXT_MIN : CLEAR_HOLD;
  localparam int TW     = $clog2(TMAX+1);
  localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE - 1);
  localparam logic [TW-1:0]  EXT_LAST = TW'(EXT_MIN - 1);
  localparam logic [TW-1:0]  CLR_LAST = TW'(CLEAR_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    ALARM      = 2'b01,
    EXTINGUISH = 2'b10,
    COOLDOWN   = 2'b11
  } zone_state_t;

  // Smoke sensors occupy the low half, heat sensors the high half.
  logic [2*ZONES-1:0] raw;
  logic [2*ZONES-1:0] filt;

  assign raw = {heat_signal, smoke_signal};

  for (genvar i = 0; i < 2*ZONES; i++) begin : g_db
    logic           f_q;
    logic [DBW-1:0] cnt_q;

    // Flipping on the last differing sample keeps the counter below DEBOUNCE.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        f_q   <= 1'b0;
        cnt_q <= '0;
      end else if (raw[i] == f_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DB_LAST) begin
        f_q   <= ~f_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign filt[i] = f_q;
  end

  for (genvar z = 0; z < ZONES; z++) begin : g_zone
    zone_state_t   st_q, st_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          mute_q, mute_d;
    logic          fs, fh;

    assign fs = filt[z];
    assign fh = filt[ZONES+z];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        st_q   <= IDLE;
        tmr_q  <= '0;
        mute_q <= 1'b0;
      end else begin
        st_q   <= st_d;
        tmr_q  <= tmr_d;
        mute_q <= mute_d;
      end
    end

    // One timer serves as the extinguish age and the cooldown clear streak.
    always_comb begin
      st_d   = st_q;
      tmr_d  = tmr_q;
      mute_d = mute_q;
      case (st_q)
        IDLE: begin
          if (fs && fh) begin
            st_d  = EXTINGUISH;
            tmr_d = '0;
          end else if (fs) begin
            st_d = ALARM;
          end
        end
        ALARM: begin
          if (fh) begin
            st_d  = EXTINGUISH;
            tmr_d = '0;
          end else if (!fs) begin
            st_d = IDLE;
          end
        end
        EXTINGUISH: begin
          if (tmr_q >= EXT_LAST && !fs && !fh) begin
            st_d  = COOLDOWN;
            tmr_d = '0;
          end else if (tmr_q < EXT_LAST) begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        COOLDOWN: begin
          if (fh) begin
            st_d  = EXTINGUISH;
            tmr_d = '0;
          end else if (fs) begin
            st_d = ALARM;
          end else if (tmr_q == CLR_LAST) begin
            st_d = IDLE;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        default: begin
          st_d  = IDLE;
          tmr_d = '0;
        end
      endcase
      if (st_d == IDLE) begin
        mute_d = 1'b0;
      end else if (silence && st_q == ALARM) begin
        mute_d = 1'b1;
      end
    end

    assign extinguish[z] = (st_q == EXTINGUISH);
    assign alarm[z]      = (st_q == EXTINGUISH) || (st_q == ALARM && !mute_q);
  end

  assign any_alarm = |alarm;

  always_comb begin
    ext_count = '0;
    for (int i = 0; i < ZONES; i++) begin
      ext_count = ext_count + CW'(extinguish[i]);
    end
  end

endmodule

// File: tb/tb_fire_zone_ctrl.sv
// Bench for fire_zone_ctrl: directed scenarios plus random sensor traffic,
// all checked against a cycle-level behavioural model of the zone rules.
module tb_fire_zone_ctrl;
  localparam int Z  = 4;
  localparam int DB = 3;
  localparam int EM = 8;
  localparam int CH = 4;
  localparam int CW = 3;
  localparam int VW = 2*Z + 1 + CW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [Z-1:0]  heat_signal = '0;
  logic [Z-1:0]  smoke_signal = '0;
  logic          silence = 1'b0;
  logic [Z-1:0]  alarm, extinguish;
  logic          any_alarm;
  logic [CW-1:0] ext_count;
  logic [VW-1:0] obs;

  int total = 0;
  int bad   = 0;

  fire_zone_ctrl #(.ZONES(Z), .DEBOUNCE(DB), .EXT_MIN(EM), .CLEAR_HOLD(CH)) dut (
    .clk(clk), .reset(reset), .heat_signal(heat_signal), .smoke_signal(smoke_signal),
    .silence(silence), .alarm(alarm), .extinguish(extinguish), .any_alarm(any_alarm),
    .ext_count(ext_count)
  );

  always #5 clk = ~clk;
  assign obs = {alarm, extinguish, any_alarm, ext_count};

  typedef enum {Z_IDLE, Z_ALARM, Z_EXT, Z_COOL} mz_t;
  mz_t m_st[Z];
  int  m_age[Z];
  bit  m_mute[Z];
  bit  m_fs[Z], m_fh[Z];
  int  m_sdiff[Z], m_hdiff[Z];

  task automatic model_reset();
    for (int z = 0; z < Z; z++) begin
      m_st[z] = Z_IDLE; m_age[z] = 0; m_mute[z] = 0;
      m_fs[z] = 0; m_fh[z] = 0; m_sdiff[z] = 0; m_hdiff[z] = 0;
    end
  endtask

  task automatic model_step();
    for (int z = 0; z < Z; z++) begin
      mz_t prev;
      bit fs, fh;
      prev = m_st[z]; fs = m_fs[z]; fh = m_fh[z];
      case (prev)
        Z_IDLE:  if (fs && fh) begin m_st[z] = Z_EXT; m_age[z] = 0; end
                 else if (fs) m_st[z] = Z_ALARM;
        Z_ALARM: if (fh) begin m_st[z] = Z_EXT; m_age[z] = 0; end
                 else if (!fs) m_st[z] = Z_IDLE;
        Z_EXT:   if (m_age[z] >= EM-1 && !fs && !fh) begin m_st[z] = Z_COOL; m_age[z] = 0; end
                 else m_age[z]++;
        Z_COOL:  if (fh) begin m_st[z] = Z_EXT; m_age[z] = 0; end
                 else if (fs) m_st[z] = Z_ALARM;
                 else begin
                   m_age[z]++;
                   if (m_age[z] == CH) m_st[z] = Z_IDLE;
                 end
        default: m_st[z] = Z_IDLE;
      endcase
      if (m_st[z] == Z_IDLE) m_mute[z] = 0;
      else if (silence && prev == Z_ALARM) m_mute[z] = 1;
      if (smoke_signal[z] != m_fs[z]) begin
        m_sdiff[z]++;
        if (m_sdiff[z] == DB) begin m_fs[z] = !m_fs[z]; m_sdiff[z] = 0; end
      end else m_sdiff[z] = 0;
      if (heat_signal[z] != m_fh[z]) begin
        m_hdiff[z]++;
        if (m_hdiff[z] == DB) begin m_fh[z] = !m_fh[z]; m_hdiff[z] = 0; end
      end else m_hdiff[z] = 0;
    end
  endtask

  function automatic logic [VW-1:0] exp_vec();
    logic [Z-1:0] a, e;
    int n;
    a = '0; e = '0; n = 0;
    for (int z = 0; z < Z; z++) begin
      e[z] = (m_st[z] == Z_EXT);
      a[z] = e[z] || (m_st[z] == Z_ALARM && !m_mute[z]);
      n += int'(e[z]);
    end
    return {a, e, |a, CW'(n)};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset) model_step();
    else model_reset();
    @(negedge clk);
  endtask

  task automatic settle();
    heat_signal = '0; smoke_signal = '0; silence = 0;
    repeat (20) tick();
  endtask

  task automatic test_reset();
    reset = 0;
    for (int i = 0; i < 5; i++) begin
      heat_signal = Z'($urandom); smoke_signal = Z'($urandom);
      tick();
      total++;
      if (obs !== '0) begin bad++; $display("FAIL reset_hold%0d got=%h want=0", i, obs); end
    end
    heat_signal = '0; smoke_signal = '0;
    reset = 1;
    tick();
    total++;
    if (obs !== exp_vec()) begin bad++; $display("FAIL reset_release got=%h want=%h", obs, exp_vec()); end
    total++;
    if (ext_count !== '0) begin bad++; $display("FAIL reset_ext_count got=%0d want=0", ext_count); end
  endtask

  task automatic test_glitch();
    smoke_signal[0] = 1; tick(); tick();
    smoke_signal[0] = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (obs !== exp_vec() || alarm[0] !== 1'b0) begin
        bad++; $display("FAIL glitch%0d got=%h want=%h", i, obs, exp_vec());
      end
    end
    smoke_signal[0] = 1;
    for (int i = 1; i <= DB+1; i++) begin
      tick();
      total++;
      if (alarm[0] !== (i == DB+1) || obs !== exp_vec()) begin
        bad++; $display("FAIL smoke_latency edge%0d got=%h want=%h", i, obs, exp_vec());
      end
    end
    smoke_signal[0] = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL smoke_clear%0d got=%h want=%h", i, obs, exp_vec()); end
    end
  endtask

  task automatic test_extinguish();
    int ext_n;
    ext_n = 0;
    smoke_signal[1] = 1; heat_signal[1] = 1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (i == DB+3) begin smoke_signal[1] = 0; heat_signal[1] = 0; end
      if (extinguish[1]) ext_n++;
      total++;
      if (obs !== exp_vec() || (i == DB+1 && (extinguish[1] !== 1'b1 || alarm[1] !== 1'b1))) begin
        bad++; $display("FAIL extinguish_seq edge%0d got=%h want=%h", i, obs, exp_vec());
      end
    end
    total++;
    if (ext_n != EM) begin bad++; $display("FAIL extinguish_min got=%0d want=%0d", ext_n, EM); end
  endtask

  task automatic test_silence();
    smoke_signal[2] = 1;
    repeat (DB+1) tick();
    total++;
    if (alarm[2] !== 1'b1) begin bad++; $display("FAIL silence_pre got=%b want=1", alarm[2]); end
    silence = 1; tick(); silence = 0;
    total++;
    if (alarm[2] !== 1'b0 || any_alarm !== 1'b0 || obs !== exp_vec()) begin
      bad++; $display("FAIL silence_mute got=%h want=%h", obs, exp_vec());
    end
    smoke_signal[3] = 1;
    repeat (DB+1) tick();
    total++;
    if (alarm[3] !== 1'b1 || obs !== exp_vec()) begin
      bad++; $display("FAIL silence_late_zone got=%h want=%h", obs, exp_vec());
    end
    heat_signal[2] = 1;
    repeat (DB+1) tick();
    total++;
    if (alarm[2] !== 1'b1 || extinguish[2] !== 1'b1 || obs !== exp_vec()) begin
      bad++; $display("FAIL silence_ext got=%h want=%h", obs, exp_vec());
    end
    heat_signal = '0; smoke_signal = '0;
    for (int i = 0; i < 25; i++) begin
      tick();
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL silence_tail%0d got=%h want=%h", i, obs, exp_vec()); end
    end
  endtask

  task automatic test_all_zones();
    int n, ext_n;
    bit dropped;
    smoke_signal = '1; heat_signal = '1;
    repeat (DB+1) tick();
    total++;
    if (ext_count !== CW'(Z) || obs !== exp_vec()) begin
      bad++; $display("FAIL all_zones got=%h want=%h", obs, exp_vec());
    end
    tick(); tick();
    smoke_signal = '0; heat_signal = '0;
    for (n = 0; n < 20 && extinguish[1]; n++) begin
      tick();
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL all_zones_drain%0d got=%h want=%h", n, obs, exp_vec()); end
    end
    total++;
    if (extinguish[1] !== 1'b0) begin bad++; $display("FAIL all_zones_timeout got=%b want=0", extinguish[1]); end
    heat_signal[1] = 1;
    ext_n = 0; dropped = 0;
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (extinguish[1]) ext_n++;
      if (ext_n == 2 && !dropped) begin heat_signal[1] = 0; dropped = 1; end
      total++;
      if (obs !== exp_vec() || (i == DB+1 && extinguish[1] !== 1'b1)) begin
        bad++; $display("FAIL reignite edge%0d got=%h want=%h", i, obs, exp_vec());
      end
    end
    total++;
    if (ext_n != EM) begin bad++; $display("FAIL reignite_min got=%0d want=%0d", ext_n, EM); end
  endtask

  task automatic test_async_reset();
    smoke_signal[0] = 1; heat_signal[0] = 1;
    repeat (DB+3) tick();
    total++;
    if (extinguish[0] !== 1'b1) begin bad++; $display("FAIL async_pre got=%b want=1", extinguish[0]); end
    #2 reset = 0;
    #1;
    total++;
    if (obs !== '0) begin bad++; $display("FAIL async_drop got=%h want=0", obs); end
    model_reset();
    tick();
    reset = 1;
    for (int i = 1; i <= DB+1; i++) begin
      tick();
      total++;
      if (extinguish[0] !== (i == DB+1) || obs !== exp_vec()) begin
        bad++; $display("FAIL async_restart edge%0d got=%h want=%h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      for (int z = 0; z < Z; z++) begin
        if ($urandom_range(0, 3) == 0) smoke_signal[z] = ~smoke_signal[z];
        if ($urandom_range(0, 3) == 0) heat_signal[z] = ~heat_signal[z];
      end
      silence = ($urandom_range(0, 9) == 0);
      tick();
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL random%0d got=%h want=%h", i, obs, exp_vec()); end
    end
    silence = 0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_glitch();
    settle();
    test_extinguish();
    settle();
    test_silence();
    settle();
    test_all_zones();
    settle();
    test_async_reset();
    settle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
